vga_vsync_gen: RTL and testbench
================================

# vga_vsync_gen

Vertical timing stage of the VGA controller, directly downstream of the horizontal pixel counter. Consumes the free-running horizontal count and its once-per-line tick, maintains the line counter, and produces registered VGA sync, display-enable and pixel-coordinate signals for the Pong renderer. Default timing is 640x480 at 60 Hz, with an 800-clock line and a 525-line frame.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_TOTAL, 525, lines per frame

Ports:
- clk  in  1  pixel clock; one clock domain only
- rst  in  1  synchronous, active-high reset
- hcount  in  13  horizontal count from upstream, 0..799
- enable_vsync  in  1  line tick from upstream; high for exactly the one cycle in which hcount==0
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- video_on  out  1  high while the current pixel is visible
- pixel_x  out  10  visible column 0..639; 0 when video_on=0
- pixel_y  out  10  visible row 0..479; 0 when video_on=0
- frame_start  out  1  one-cycle pulse on pixel (0,0) of each frame

## Operation
- State machine with two states:
  - UNSYNC: entered on reset; stays here until the first enable_vsync.
  - SYNC: entered from UNSYNC on the first enable_vsync; that line becomes line 0.
- Line counter vline (10 bits):
  - Reset value is 0.
  - In SYNC, each enable_vsync advances vline by 1; V_TOTAL-1 wraps to 0.
  - On the UNSYNC->SYNC transition, vline is loaded with 0 and is not incremented.
- Effective line for the current cycle: veff = next vline value when enable_vsync=1, otherwise vline. This keeps hcount==0 on the correct line.
- Combinational terms, computed from (hcount, veff):
  - hs_act = H_VIS+H_FP <= hcount <= H_VIS+H_FP+H_SYNC-1 (656..751 by default).
  - vs_act = V_VIS+V_FP <= veff <= V_VIS+V_FP+V_SYNC-1 (490..491).
  - vis = hcount < H_VIS and veff < V_VIS.
- Output register, updated every cycle in SYNC:
  - hsync_n = !hs_act
  - vsync_n = !vs_act
  - video_on = vis
  - pixel_x = vis ? hcount[9:0] : 0
  - pixel_y = vis ? veff : 0
  - frame_start = enable_vsync and veff==0
- Output values in UNSYNC:
  - hsync_n=1, vsync_n=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0.
- Arithmetic:
  - Compare hcount at its full 13 bits, with no truncation before comparison.
  - Any hcount >= H_VIS is not visible.
- hcount and enable_vsync are not checked for consistency. enable_vsync alone defines line boundaries.

## Timing
- All outputs are registered with a latency of 1 clock. Output at cycle t+1 reflects the inputs at cycle t.
- Reset values of all outputs: hsync_n=1, vsync_n=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0. vline=0, state=UNSYNC.
- Reset asserted mid-frame:
  - Outputs reach their reset values at the next edge.
  - After release, the block waits in UNSYNC for the next enable_vsync, then restarts at line 0.
  - The upstream counter is not reset and keeps running.
- enable_vsync together with rst: reset wins and the tick is ignored.
- The first enable_vsync after reset:
  - The block enters SYNC.
  - The output register is loaded from the same cycle's inputs, so frame_start=1 one cycle later.
- Per frame: exactly one frame_start, 2 lines of vsync_n=0, 480 lines each with 640 video_on cycles, and 96-clock hsync_n pulses on every line, including blanking lines.
- Line wrap: enable_vsync at vline=524 gives veff=0 and a frame_start pulse.

## Test plan
- Reset, then drive an upstream model from hcount=0 with enable_vsync -> frame_start=1 one cycle later. pixel_x=0, pixel_y=0, video_on=1 on that same cycle.
- Run one full line (800 cycles) -> hsync_n=0 for exactly 96 cycles, first low output one cycle after hcount=656. video_on=1 for cycles 1..640 after the tick.
- Run 2 full frames (840000 cycles):
  - frame_start pulses 420000 cycles apart.
  - video_on high-count per frame is 307200.
  - vsync_n=0 for 1600 cycles, starting one cycle after enable_vsync of line 490.
- Assert rst at line 200, hcount 300 -> all outputs at reset values next cycle. After release, outputs stay idle until the next tick, then frame_start=1 and pixel_y restarts at 0.
- Hold rst high across an enable_vsync cycle -> state stays UNSYNC and outputs stay idle. The first tick after release starts line 0.
- Check pixel_y at hcount=0 of line 479 (a tick cycle) -> pixel_y=479 one cycle later. At line 480, video_on=0 for the whole line.

Source files
------------

// File: rtl/vga_vsync_gen.sv
// Vertical timing stage of the VGA controller: tracks the line counter from the
// upstream line tick and registers sync, display-enable and pixel coordinates.
module vga_vsync_gen #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] hcount,
  input  logic        enable_vsync,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start
);

  // Horizontal bounds kept at the full 13-bit width of hcount so that counts
  // beyond 1023 never alias back into the visible or sync windows.
  localparam logic [12:0] H_VIS_W   = 13'(H_VIS);
  localparam logic [12:0] HS_START  = 13'(H_VIS + H_FP);
  localparam logic [12:0] HS_END    = 13'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_VIS_W   = 10'(V_VIS);
  localparam logic [9:0]  VS_START  = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] vline, vline_nxt;
  logic [9:0] veff_p0;
  logic       hs_act_p0, vs_act_p0, vis_p0;

  // State and line counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNSYNC;
      vline <= '0;
    end else begin
      state <= state_nxt;
      vline <= vline_nxt;
    end
  end

  // Next state and next line: the first tick locks onto line 0, later ticks advance and wrap.
  always_comb begin
    state_nxt = state;
    vline_nxt = vline;
    case (state)
      UNSYNC: begin
        if (enable_vsync) begin
          state_nxt = SYNC;
          vline_nxt = '0;
        end
      end
      SYNC: begin
        if (enable_vsync) begin
          vline_nxt = (vline == V_LAST) ? 10'd0 : vline + 10'd1;
        end
      end
      default: begin
        state_nxt = UNSYNC;
        vline_nxt = '0;
      end
    endcase
  end

  // Stage p0: timing terms from the current pixel; on a tick cycle the pixel at
  // hcount==0 already belongs to the new line, so the next line value is used.
  always_comb begin
    veff_p0   = enable_vsync ? vline_nxt : vline;
    hs_act_p0 = (hcount >= HS_START) && (hcount <= HS_END);
    vs_act_p0 = (veff_p0 >= VS_START) && (veff_p0 <= VS_END);
    vis_p0    = (hcount < H_VIS_W) && (veff_p0 < V_VIS_W);
  end

  // Stage p1: output register, idle until the block has locked onto a line tick.
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != SYNC)) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync_n     <= !hs_act_p0;
      vsync_n     <= !vs_act_p0;
      video_on    <= vis_p0;
      pixel_x     <= vis_p0 ? hcount[9:0] : 10'd0;
      pixel_y     <= vis_p0 ? veff_p0 : 10'd0;
      frame_start <= enable_vsync && (veff_p0 == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_vsync_gen.sv
// Bench for vga_vsync_gen using a reduced timing set so that full frames stay short.
module tb_vga_vsync_gen;

  localparam int HV = 64;
  localparam int HF = 8;
  localparam int HS = 16;
  localparam int HT = 100;
  localparam int VV = 48;
  localparam int VF = 3;
  localparam int VS = 2;
  localparam int VT = 60;

  localparam logic [23:0] IDLE = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] hcount;
  logic        enable_vsync;
  logic        hsync_n, vsync_n, video_on, frame_start;
  logic [9:0]  pixel_x, pixel_y;
  logic [23:0] got_v;
  logic [23:0] exp_v;

  int errors = 0;
  int checks = 0;
  int uh = 0;
  logic m_synced = 1'b0;
  int m_nticks = 0;

  vga_vsync_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .enable_vsync(enable_vsync),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
  );

  always #5 clk = !clk;

  assign got_v = {hsync_n, vsync_n, video_on, pixel_x, pixel_y, frame_start};

  // Reference: line number is the count of ticks since locking, modulo the frame length.
  function automatic logic [23:0] model(input logic r, input logic t, input int hc);
    int line;
    logic vis, hs, vs, fs;
    logic [9:0] px, py;
    if (r) begin
      m_synced = 1'b0;
      m_nticks = 0;
      return IDLE;
    end
    if (t) begin
      m_synced = 1'b1;
      m_nticks = m_nticks + 1;
    end
    if (!m_synced) return IDLE;
    line = (m_nticks - 1) % VT;
    hs  = (hc >= HV + HF) && (hc < HV + HF + HS);
    vs  = (line >= VV + VF) && (line < VV + VF + VS);
    vis = (hc < HV) && (line < VV);
    px  = vis ? 10'(hc % 1024) : 10'd0;
    py  = vis ? 10'(line) : 10'd0;
    fs  = t && (line == 0);
    return {!hs, !vs, vis, px, py, fs};
  endfunction

  task automatic drive(input logic r, input logic t, input int hc);
    rst = r;
    enable_vsync = t;
    hcount = 13'(hc);
    exp_v = model(r, t, hc);
    @(posedge clk);
    #1;
  endtask

  // Upstream horizontal counter: free running, never reset.
  task automatic up(input logic r);
    drive(r, uh == 0, uh);
    uh = (uh + 1) % HT;
  endtask

  task automatic test_reset();
    int n, bad;
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) up(1'b1);
    checks++;
    if (got_v !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got_v, IDLE);
    end
    bad = 0;
    while (uh != 0) begin
      up(1'b0);
      if (got_v !== IDLE) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_before_tick: %0d non-idle cycles, expected 0", bad);
    end
  endtask

  task automatic test_first_line();
    int bad, hs_cnt, hs_first, vid_cnt, vid_first, vid_last;
    logic [23:0] bg, be;
    bad = 0; hs_cnt = 0; hs_first = -1; vid_cnt = 0; vid_first = -1; vid_last = -1;
    bg = '0; be = '0;
    for (int k = 0; k < HT; k++) begin
      up(1'b0);
      if (got_v !== exp_v) begin
        if (bad == 0) begin bg = got_v; be = exp_v; end
        bad++;
      end
      if (k == 0) begin
        checks++;
        if (frame_start !== 1'b1) begin
          errors++; $display("FAIL first_frame_start: got %b expected 1", frame_start);
        end
        checks++;
        if (video_on !== 1'b1) begin
          errors++; $display("FAIL first_video_on: got %b expected 1", video_on);
        end
        checks++;
        if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
          errors++; $display("FAIL first_pixel: got x=%0d y=%0d expected 0 0", pixel_x, pixel_y);
        end
      end
      if (hsync_n === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
      end
      if (video_on === 1'b1) begin
        vid_cnt++;
        if (vid_first < 0) vid_first = k;
        vid_last = k;
      end
    end
    checks++;
    if (hs_cnt != HS) begin
      errors++; $display("FAIL hsync_width: got %0d expected %0d", hs_cnt, HS);
    end
    checks++;
    if (hs_first != HV + HF) begin
      errors++; $display("FAIL hsync_start: got %0d expected %0d", hs_first, HV + HF);
    end
    checks++;
    if (vid_cnt != HV || vid_first != 0 || vid_last != HV - 1) begin
      errors++;
      $display("FAIL line_video: got cnt=%0d first=%0d last=%0d expected %0d 0 %0d",
               vid_cnt, vid_first, vid_last, HV, HV - 1);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL first_line_model: %0d cycles differ, first got %h expected %h", bad, bg, be);
    end
  endtask

  task automatic test_frames();
    int bad, vid_cnt, vs_cnt, vs_first, py_last, vid_line;
    int fsq[$];
    logic [23:0] bg, be;
    bad = 0; vid_cnt = 0; vs_cnt = 0; vs_first = -1; py_last = -1; vid_line = 0;
    bg = '0; be = '0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      up(1'b0);
      if (got_v !== exp_v) begin
        if (bad == 0) begin bg = got_v; be = exp_v; end
        bad++;
      end
      if (frame_start === 1'b1) fsq.push_back(i);
      if (video_on === 1'b1) vid_cnt++;
      if (vsync_n === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = i;
      end
      if (i == (VV - 2) * HT) py_last = int'(pixel_y);
      if (i >= (VV - 1) * HT && i < VV * HT && video_on !== 1'b0) vid_line++;
    end
    checks++;
    if (fsq.size() != 2) begin
      errors++; $display("FAIL frame_start_count: got %0d expected 2", fsq.size());
    end else begin
      checks++;
      if (fsq[0] != (VT - 1) * HT) begin
        errors++; $display("FAIL frame_start_pos: got %0d expected %0d", fsq[0], (VT - 1) * HT);
      end
      checks++;
      if (fsq[1] - fsq[0] != HT * VT) begin
        errors++; $display("FAIL frame_period: got %0d expected %0d", fsq[1] - fsq[0], HT * VT);
      end
    end
    checks++;
    if (vid_cnt != 2 * HV * VV) begin
      errors++; $display("FAIL video_count: got %0d expected %0d", vid_cnt, 2 * HV * VV);
    end
    checks++;
    if (vs_cnt != 2 * VS * HT) begin
      errors++; $display("FAIL vsync_count: got %0d expected %0d", vs_cnt, 2 * VS * HT);
    end
    checks++;
    if (vs_first != (VV + VF - 1) * HT) begin
      errors++; $display("FAIL vsync_start: got %0d expected %0d", vs_first, (VV + VF - 1) * HT);
    end
    checks++;
    if (py_last != VV - 1) begin
      errors++; $display("FAIL last_row_y: got %0d expected %0d", py_last, VV - 1);
    end
    checks++;
    if (vid_line != 0) begin
      errors++; $display("FAIL blank_line_video: got %0d visible cycles expected 0", vid_line);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL frames_model: %0d cycles differ, first got %h expected %h", bad, bg, be);
    end
  endtask

  task automatic test_mid_reset();
    int bad, idle_bad, n;
    logic [23:0] bg, be;
    bad = 0; idle_bad = 0; bg = '0; be = '0;
    for (int i = 0; i < 19 * HT + 30; i++) begin
      up(1'b0);
      if (got_v !== exp_v) begin
        if (bad == 0) begin bg = got_v; be = exp_v; end
        bad++;
      end
    end
    up(1'b1);
    checks++;
    if (got_v !== IDLE) begin
      errors++; $display("FAIL mid_reset_state: got %h expected %h", got_v, IDLE);
    end
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) up(1'b1);
    while (uh != 0) begin
      up(1'b0);
      if (got_v !== IDLE) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin
      errors++; $display("FAIL mid_reset_idle: %0d non-idle cycles, expected 0", idle_bad);
    end
    up(1'b0);
    checks++;
    if (frame_start !== 1'b1 || pixel_y !== 10'd0 || video_on !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_restart: got fs=%b y=%0d vid=%b expected 1 0 1", frame_start, pixel_y, video_on);
    end
    for (int i = 0; i < HT - 1; i++) begin
      up(1'b0);
      if (got_v !== exp_v) begin
        if (bad == 0) begin bg = got_v; be = exp_v; end
        bad++;
      end
    end
    up(1'b0);
    checks++;
    if (pixel_y !== 10'd1 || frame_start !== 1'b0) begin
      errors++; $display("FAIL mid_reset_line1: got y=%0d fs=%b expected 1 0", pixel_y, frame_start);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mid_reset_model: %0d cycles differ, first got %h expected %h", bad, bg, be);
    end
  endtask

  task automatic test_rst_over_tick();
    int idle_bad;
    idle_bad = 0;
    while (uh != HT - 2) up(1'b0);
    for (int i = 0; i < 4; i++) begin
      up(1'b1);
      if (got_v !== IDLE) idle_bad++;
    end
    while (uh != 0) begin
      up(1'b0);
      if (got_v !== IDLE) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin
      errors++; $display("FAIL rst_tick_idle: %0d non-idle cycles, expected 0", idle_bad);
    end
    up(1'b0);
    checks++;
    if (frame_start !== 1'b1 || pixel_y !== 10'd0) begin
      errors++; $display("FAIL rst_tick_restart: got fs=%b y=%0d expected 1 0", frame_start, pixel_y);
    end
  endtask

  task automatic test_hcount_wide();
    drive(1'b0, 1'b0, 1024 + 5);
    checks++;
    if (video_on !== 1'b0 || pixel_x !== 10'd0) begin
      errors++; $display("FAIL wide_hcount_vis: got vid=%b x=%0d expected 0 0", video_on, pixel_x);
    end
    drive(1'b0, 1'b0, 1024 + HV + HF);
    checks++;
    if (hsync_n !== 1'b1) begin
      errors++; $display("FAIL wide_hcount_hsync: got %b expected 1", hsync_n);
    end
    drive(1'b0, 1'b0, 5);
    checks++;
    if (video_on !== 1'b1 || pixel_x !== 10'd5) begin
      errors++; $display("FAIL narrow_hcount_vis: got vid=%b x=%0d expected 1 5", video_on, pixel_x);
    end
  endtask

  task automatic test_random();
    int bad, hc;
    logic r, t;
    logic [23:0] bg, be;
    bad = 0; bg = '0; be = '0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 1499) == 0);
      t = ($urandom_range(0, 29) == 0);
      hc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, HT - 1));
      drive(r, t, hc);
      if (got_v !== exp_v) begin
        if (bad == 0) begin bg = got_v; be = exp_v; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL random_model: %0d cycles differ, first got %h expected %h", bad, bg, be);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable_vsync = 1'b0;
    hcount = '0;
    uh = $urandom_range(0, HT - 1);
    test_reset();
    test_first_line();
    test_frames();
    test_mid_reset();
    test_rst_over_tick();
    test_hcount_wide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
